// File: rtl/multicycle_control.sv
// multicycle_control: instruction sequencer for the multi-cycle RV32I-subset core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module multicycle_control (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  Funct3,
  input  logic [6:0]  Funct7,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        ImmReg,
  output logic        WDSrc,
  output logic        MemToReg,
  output logic [2:0]  ALUControl,
  output logic [2:0]  State_O,
  output logic        Illegal,
  output logic [31:0] Retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_LUI   = 3'd4
  } instr_class_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       imm_reg;
    logic       wd_src;
    logic       mem_to_reg;
    logic [2:0] alu_control;
    logic       illegal;
  } strobes_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_RSVD  = 3'b011;
  localparam logic [2:0] F3_SRL   = 3'b101;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  function automatic logic [2:0] funct3_to_alu(input logic [2:0] f3);
    logic [2:0] alu;
    case (f3)
      3'b000:  alu = ALU_ADD;
      3'b111:  alu = ALU_AND;
      3'b110:  alu = ALU_OR;
      3'b100:  alu = ALU_XOR;
      3'b001:  alu = ALU_SLL;
      3'b101:  alu = ALU_SRL;
      3'b010:  alu = ALU_SLT;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // Strobes are a pure function of the state and the class latched in DECODE.
  function automatic strobes_t moore_decode(input state_t st, input instr_class_t cls,
                                            input logic [2:0] alu);
    strobes_t s;
    s = strobes_t'(11'd0);
    case (st)
      EXEC: begin
        s.alu_control = alu;
        s.alu_src     = (cls != CLS_R);
        s.imm_reg     = (cls == CLS_STORE);
      end
      MEM: begin
        s.alu_control = alu;
        s.alu_src     = 1'b1;
        s.imm_reg     = (cls == CLS_STORE);
        s.mem_read    = (cls == CLS_LOAD);
        s.mem_write   = (cls == CLS_STORE);
      end
      WB: begin
        s.reg_write  = 1'b1;
        s.mem_to_reg = (cls == CLS_LOAD);
        s.wd_src     = (cls == CLS_LUI);
      end
      TRAP: begin
        s.illegal = 1'b1;
      end
      default: begin
        s = strobes_t'(11'd0);
      end
    endcase
    return s;
  endfunction

  state_t       state_r;
  state_t       next_state_s;
  instr_class_t class_r;
  instr_class_t next_class_s;
  instr_class_t dec_class_s;
  logic [2:0]   alu_r;
  logic [2:0]   next_alu_s;
  logic [2:0]   dec_alu_s;
  logic         dec_legal_s;
  logic         retire_s;
  logic [31:0]  retired_r;
  logic [31:0]  retired_next_s;
  strobes_t     strobes_r;
  strobes_t     next_strobes_s;

  // Classify the instruction register contents and check the encoding is legal.
  always_comb begin
    dec_legal_s = 1'b0;
    dec_class_s = CLS_R;
    dec_alu_s   = ALU_ADD;
    case (Opcode)
      OP_R: begin
        dec_class_s = CLS_R;
        dec_alu_s   = funct3_to_alu(Funct3);
        if (Funct3 == F3_RSVD) begin
          dec_legal_s = 1'b0;
        end else if (Funct7 == F7_BASE) begin
          dec_legal_s = 1'b1;
        end else if ((Funct7 == F7_ALT) && (Funct3 == F3_ADD)) begin
          dec_legal_s = 1'b1;
          dec_alu_s   = ALU_SUB;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OP_I: begin
        dec_class_s = CLS_I;
        dec_alu_s   = funct3_to_alu(Funct3);
        if (Funct3 == F3_RSVD) begin
          dec_legal_s = 1'b0;
        end else if (((Funct3 == F3_SLL) || (Funct3 == F3_SRL)) && (Funct7 != F7_BASE)) begin
          dec_legal_s = 1'b0;
        end else begin
          dec_legal_s = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_class_s = CLS_LOAD;
        dec_legal_s = (Funct3 == F3_WORD);
      end
      OP_STORE: begin
        dec_class_s = CLS_STORE;
        dec_legal_s = (Funct3 == F3_WORD);
      end
      OP_LUI: begin
        dec_class_s = CLS_LUI;
        dec_legal_s = 1'b1;
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; class and ALU op are captured only while leaving DECODE.
  always_comb begin
    next_state_s = state_r;
    next_class_s = class_r;
    next_alu_s   = alu_r;
    retire_s     = 1'b0;
    case (state_r)
      FETCH: begin
        if (IMemReady) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        next_class_s = dec_class_s;
        next_alu_s   = dec_alu_s;
        if (!dec_legal_s) begin
          next_state_s = TRAP;
        end else if (dec_class_s == CLS_LUI) begin
          next_state_s = WB;
        end else begin
          next_state_s = EXEC;
        end
      end
      EXEC: begin
        if ((class_r == CLS_LOAD) || (class_r == CLS_STORE)) begin
          next_state_s = MEM;
        end else begin
          next_state_s = WB;
        end
      end
      MEM: begin
        if (!DMemReady) begin
          next_state_s = MEM;
        end else if (class_r == CLS_LOAD) begin
          next_state_s = WB;
        end else begin
          next_state_s = FETCH;
          retire_s     = 1'b1;
        end
      end
      WB: begin
        next_state_s = FETCH;
        retire_s     = 1'b1;
      end
      TRAP: begin
        next_state_s = TRAP;
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // Strobes for the upcoming state are computed here so the output flops hold them.
  always_comb begin
    next_strobes_s = moore_decode(next_state_s, next_class_s, next_alu_s);
    if (retire_s) begin
      retired_next_s = retired_r + 32'd1;
    end else begin
      retired_next_s = retired_r;
    end
  end

  // State, decoded class, strobe and retirement registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= FETCH;
      class_r   <= CLS_R;
      alu_r     <= ALU_ADD;
      strobes_r <= strobes_t'(11'd0);
      retired_r <= 32'd0;
    end else begin
      state_r   <= next_state_s;
      class_r   <= next_class_s;
      alu_r     <= next_alu_s;
      strobes_r <= next_strobes_s;
      retired_r <= retired_next_s;
    end
  end

  // PC and IR loads respond in the same cycle the instruction word arrives.
  assign PCWrite    = (state_r == FETCH) && IMemReady;
  assign IRWrite    = (state_r == FETCH) && IMemReady;
  assign RegWrite   = strobes_r.reg_write;
  assign MemRead    = strobes_r.mem_read;
  assign MemWrite   = strobes_r.mem_write;
  assign ALUSrc     = strobes_r.alu_src;
  assign ImmReg     = strobes_r.imm_reg;
  assign WDSrc      = strobes_r.wd_src;
  assign MemToReg   = strobes_r.mem_to_reg;
  assign ALUControl = strobes_r.alu_control;
  assign Illegal    = strobes_r.illegal;
  assign State_O    = state_r;
  assign Retired    = retired_r;

endmodule
